// File: rtl/axi_adc_capture_seq.sv
// Capture sequencer: ADC clock generation, byte-to-word packing through a small FIFO,
// and splitting of the destination buffer into write commands plus a beat stream.
module axi_adc_capture_seq #(
    parameter int DIV_W       = 16,
    parameter int SIZE_W      = 24,
    parameter int BURST_BYTES = 64,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DIV_W-1:0]  cfg_clk_div,
    input  logic [31:0]       cfg_dst_addr,
    input  logic [SIZE_W-1:0] cfg_dst_size,
    input  logic              cfg_repeat,
    input  logic              ctl_start,
    input  logic              ctl_stop,
    output logic              busy,
    output logic              pass_done,
    output logic              done,
    output logic              err_cfg,
    output logic              overrun,
    output logic              adc_clk,
    input  logic [7:0]        adc_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [31:0]       cmd_addr,
    output logic [7:0]        cmd_len,
    output logic              wdata_valid,
    input  logic              wdata_ready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;

    logic [DIV_W-1:0]  div_q, div_cnt;
    logic [31:0]       base_q;
    logic [SIZE_W-1:0] size_q, samp_cnt, cmd_off, cmd_bytes;
    logic              rpt_q, samp_halt, cmd_act, last_cmd;
    logic [1:0]        pack_idx;
    logic [31:0]       pack_word, new_word;
    logic [3:0]        new_strb;
    logic [7:0]        beats_left;
    logic [35:0]       mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;

    function automatic logic [SIZE_W-1:0] chunk(input logic [SIZE_W-1:0] rem);
        return (rem > SIZE_W'(BURST_BYTES)) ? SIZE_W'(BURST_BYTES) : rem;
    endfunction

    function automatic logic [7:0] beats_m1(input logic [SIZE_W-1:0] bytes);
        return 8'((bytes - 1'b1) >> 2);
    endfunction

    logic fifo_empty, fifo_full, cfg_ok, cmd_hs, beat_hs, last_hs, pop;
    logic sampling, smp_tick, pass_end_smp, word_done, push, ovf, outstanding, to_done;
    logic [SIZE_W-1:0] nxt_off, nxt_bytes;
    logic [35:0] head;

    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head         = mem[rd_ptr[AW-1:0]];
    assign cfg_ok       = (cfg_clk_div != '0) && (cfg_dst_size != '0) && (cfg_dst_addr[1:0] == 2'b00);

    // In DRAIN an empty FIFO turns the remaining beats into zero-strobe pads.
    assign wdata_valid  = cmd_act && (!fifo_empty || state == DRAIN);
    assign wdata        = (wdata_valid && !fifo_empty) ? head[31:0]  : '0;
    assign wstrb        = (wdata_valid && !fifo_empty) ? head[35:32] : '0;
    assign wlast        = wdata_valid && (beats_left == 8'd0);

    assign cmd_hs       = cmd_valid && cmd_ready;
    assign beat_hs      = wdata_valid && wdata_ready;
    assign last_hs      = beat_hs && wlast;
    assign pop          = beat_hs && !fifo_empty;

    // Samples are taken on the edge that drives adc_clk from high to low.
    assign sampling     = (state == RUN) && !samp_halt;
    assign smp_tick     = sampling && adc_clk && (div_cnt == div_q - 1'b1);
    assign pass_end_smp = (samp_cnt == size_q - 1'b1);
    assign word_done    = smp_tick && (pack_idx == 2'd3 || pass_end_smp);
    assign push         = word_done && !fifo_full;
    assign ovf          = word_done && fifo_full;

    assign nxt_off      = last_cmd ? '0 : cmd_off + cmd_bytes;
    assign nxt_bytes    = chunk(size_q - nxt_off);
    assign outstanding  = cmd_valid || (cmd_act && !last_hs);

    assign to_done = ((state == RUN) &&
                      ((ctl_stop && !outstanding) ||
                       (!ctl_stop && !ovf && last_hs && last_cmd && !rpt_q))) ||
                     ((state == DRAIN) && (last_hs || (!cmd_valid && !cmd_act)));

    always_comb begin
        new_word = (pack_idx == 2'd0) ? '0 : pack_word;
        new_word[{pack_idx, 3'b000} +: 8] = adc_data;
        case (pack_idx)
            2'd0:    new_strb = 4'b0001;
            2'd1:    new_strb = 4'b0011;
            2'd2:    new_strb = 4'b0111;
            default: new_strb = 4'b1111;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {new_strb, new_word};
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            pass_done  <= 1'b0;
            done       <= 1'b0;
            err_cfg    <= 1'b0;
            overrun    <= 1'b0;
            adc_clk    <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_addr   <= '0;
            cmd_len    <= '0;
            div_q      <= '0;
            div_cnt    <= '0;
            base_q     <= '0;
            size_q     <= '0;
            rpt_q      <= 1'b0;
            samp_halt  <= 1'b1;
            samp_cnt   <= '0;
            pack_idx   <= '0;
            pack_word  <= '0;
            cmd_act    <= 1'b0;
            last_cmd   <= 1'b0;
            cmd_off    <= '0;
            cmd_bytes  <= '0;
            beats_left <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            pass_done <= 1'b0;
            done      <= 1'b0;
            err_cfg   <= 1'b0;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            if (cmd_hs) begin
                cmd_valid  <= 1'b0;
                cmd_act    <= 1'b1;
                beats_left <= cmd_len;
            end
            if (beat_hs) begin
                beats_left <= beats_left - 1'b1;
                if (wlast) cmd_act <= 1'b0;
            end
            if (ovf) overrun <= 1'b1;

            if (sampling) begin
                if (div_cnt == div_q - 1'b1) begin
                    div_cnt <= '0;
                    adc_clk <= ~adc_clk;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
            if (smp_tick) begin
                pack_word <= new_word;
                if (pass_end_smp) begin
                    samp_cnt  <= '0;
                    pack_idx  <= '0;
                    samp_halt <= !rpt_q;
                end else begin
                    samp_cnt <= samp_cnt + 1'b1;
                    pack_idx <= pack_idx + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (ctl_start) begin
                        if (cfg_ok) begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            overrun   <= 1'b0;
                            div_q     <= cfg_clk_div;
                            base_q    <= cfg_dst_addr;
                            size_q    <= cfg_dst_size;
                            rpt_q     <= cfg_repeat;
                            div_cnt   <= '0;
                            adc_clk   <= 1'b0;
                            samp_halt <= 1'b0;
                            samp_cnt  <= '0;
                            pack_idx  <= '0;
                            wr_ptr    <= '0;
                            rd_ptr    <= '0;
                            cmd_valid <= 1'b1;
                            cmd_addr  <= cfg_dst_addr;
                            cmd_len   <= beats_m1(chunk(cfg_dst_size));
                            cmd_off   <= '0;
                            cmd_bytes <= chunk(cfg_dst_size);
                            last_cmd  <= (cfg_dst_size <= SIZE_W'(BURST_BYTES));
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (last_hs && last_cmd) pass_done <= 1'b1;
                    if (ctl_stop || ovf) begin
                        samp_halt <= 1'b1;
                        adc_clk   <= 1'b0;
                        div_cnt   <= '0;
                        if (ovf || outstanding) state <= DRAIN;
                    end else if (last_hs && !(last_cmd && !rpt_q)) begin
                        cmd_valid <= 1'b1;
                        cmd_addr  <= base_q + 32'(nxt_off);
                        cmd_len   <= beats_m1(nxt_bytes);
                        cmd_off   <= nxt_off;
                        cmd_bytes <= nxt_bytes;
                        last_cmd  <= (nxt_off + nxt_bytes == size_q);
                    end
                end
                DONE:    state <= IDLE;
                default: ;
            endcase

            // Leaving for DONE flushes any residual words and parks the sampler.
            if (to_done) begin
                state     <= DONE;
                done      <= 1'b1;
                busy      <= 1'b0;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                adc_clk   <= 1'b0;
                samp_halt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_adc_capture_seq.sv
// Directed bench for the ADC capture sequencer; a negedge monitor logs handshakes and models the ADC.
`timescale 1ns/1ps
module tb_axi_adc_capture_seq;

    localparam logic [31:0] BASE = 32'h2000_0000;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] cfg_clk_div;
    logic [31:0] cfg_dst_addr;
    logic [23:0] cfg_dst_size;
    logic        cfg_repeat, ctl_start, ctl_stop;
    logic        busy, pass_done, done, err_cfg, overrun, adc_clk;
    logic [7:0]  adc_data = 8'h00;
    logic        cmd_valid, cmd_ready;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wdata_valid, wdata_ready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    axi_adc_capture_seq dut (
        .aclk(aclk), .areset(areset),
        .cfg_clk_div(cfg_clk_div), .cfg_dst_addr(cfg_dst_addr), .cfg_dst_size(cfg_dst_size),
        .cfg_repeat(cfg_repeat), .ctl_start(ctl_start), .ctl_stop(ctl_stop),
        .busy(busy), .pass_done(pass_done), .done(done), .err_cfg(err_cfg), .overrun(overrun),
        .adc_clk(adc_clk), .adc_data(adc_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast)
    );

    always #2 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    logic clr = 1'b1;

    int cyc = 0, cmd_cnt, beat_cnt, pad_cnt, pd_cnt, done_cnt, err_cnt, cv_seen;
    int rise_cnt, prev_rise, last_rise, smp_n;
    logic adc_q = 1'b0;
    logic [31:0] addr_q[$];
    logic [7:0]  len_q[$];
    logic [31:0] data_q[$];
    logic [3:0]  strb_q[$];
    logic        last_q[$];

    // ADC model: a new sample value is presented after each adc_clk rise.
    always @(negedge aclk) begin
        cyc = cyc + 1;
        if (clr) begin
            cmd_cnt = 0; beat_cnt = 0; pad_cnt = 0; pd_cnt = 0; done_cnt = 0;
            err_cnt = 0; cv_seen = 0; rise_cnt = 0; prev_rise = 0; last_rise = 0; smp_n = 0;
            addr_q.delete(); len_q.delete(); data_q.delete(); strb_q.delete(); last_q.delete();
        end else begin
            if (cmd_valid) cv_seen = cv_seen + 1;
            if (cmd_valid && cmd_ready) begin
                cmd_cnt = cmd_cnt + 1;
                addr_q.push_back(cmd_addr);
                len_q.push_back(cmd_len);
            end
            if (wdata_valid && wdata_ready) begin
                beat_cnt = beat_cnt + 1;
                if (wstrb == 4'b0000) pad_cnt = pad_cnt + 1;
                data_q.push_back(wdata);
                strb_q.push_back(wstrb);
                last_q.push_back(wlast);
            end
            if (pass_done) pd_cnt = pd_cnt + 1;
            if (done) done_cnt = done_cnt + 1;
            if (err_cfg) err_cnt = err_cnt + 1;
            if (adc_clk && !adc_q) begin
                rise_cnt = rise_cnt + 1;
                prev_rise = last_rise;
                last_rise = cyc;
                adc_data = 8'(smp_n * 7 + 3);
                smp_n = smp_n + 1;
            end
        end
        adc_q = adc_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] addr_at(input int i);
        return (i < addr_q.size()) ? addr_q[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_ctl"}, 64'({busy, pass_done, done, err_cfg, overrun, adc_clk, cmd_valid,
                                wdata_valid, wlast, wstrb}), 64'd0);
        chk({tag, "_cmd"}, 64'({cmd_addr, cmd_len}), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata), 64'd0);
    endtask

    task automatic start_run(input logic [15:0] div, input logic [23:0] size, input logic rpt);
        cfg_clk_div = div; cfg_dst_addr = BASE; cfg_dst_size = size; cfg_repeat = rpt;
        clr = 1'b1;
        @(posedge aclk); #1;
        clr = 1'b0;
        ctl_start = 1'b1;
        @(posedge aclk); #1;
        ctl_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            @(negedge aclk); #1;
        end
        chk(tag, 64'(done_cnt), 64'd1);
        @(posedge aclk); #1;
    endtask

    task automatic check_data(input string tag, input int nbytes);
        int bad;
        logic [31:0] ew;
        logic [3:0]  es;
        bad = (data_q.size() == (nbytes + 3) / 4) ? 0 : 1;
        for (int b = 0; b < data_q.size(); b++) begin
            ew = '0; es = '0;
            for (int i = 0; i < 4; i++) begin
                if (4 * b + i < nbytes) begin
                    ew[8*i +: 8] = 8'((4 * b + i) * 7 + 3);
                    es[i] = 1'b1;
                end
            end
            if (data_q[b] !== ew || strb_q[b] !== es) bad++;
        end
        chk(tag, 64'(bad), 64'd0);
    endtask

    task automatic bad_start(input logic [15:0] div, input logic [31:0] addr,
                             input logic [23:0] size, input string tag);
        cfg_clk_div = div; cfg_dst_addr = addr; cfg_dst_size = size;
        ctl_start = 1'b1;
        @(posedge aclk); #1;
        ctl_start = 1'b0;
        chk({tag, "_err"}, 64'(err_cfg), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        @(posedge aclk); #1;
    endtask

    task automatic run_size55(input string tag);
        start_run(16'd7, 24'd55, 1'b0);
        wait_done(3000, {tag, "_done"});
        chk({tag, "_cmds"}, 64'(cmd_cnt), 64'd1);
        chk({tag, "_len"}, 64'(len_q.size() > 0 ? len_q[0] : 8'hFF), 64'd13);
        chk({tag, "_beats"}, 64'(beat_cnt), 64'd14);
        chk({tag, "_last_strb"}, 64'(strb_q.size() == 14 ? strb_q[13] : 4'hF), 64'b0111);
        chk({tag, "_wlast"}, 64'(last_q.size() == 14 ? last_q[13] : 1'b0), 64'd1);
        check_data({tag, "_data"}, 55);
    endtask

    initial begin
        areset = 1'b1; cfg_clk_div = '0; cfg_dst_addr = '0; cfg_dst_size = '0; cfg_repeat = 1'b0;
        ctl_start = 1'b0; ctl_stop = 1'b0; cmd_ready = 1'b1; wdata_ready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk); #1;
        check_outputs_zero("reset");
        @(posedge aclk); #1;
        areset = 1'b0;

        // 1: four full bursts, adc_clk period 6
        start_run(16'd3, 24'd256, 1'b0);
        @(negedge aclk); #1;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cmd_first", 64'({cmd_valid, cmd_addr, cmd_len}), 64'({1'b1, BASE, 8'd15}));
        wait_done(5000, "t1_done");
        chk("t1_cmds", 64'(cmd_cnt), 64'd4);
        for (int i = 0; i < 4; i++)
            chk("t1_addr", 64'(addr_at(i)), 64'(BASE + 32'(64 * i)));
        chk("t1_lens", 64'({len_q.size() > 3 ? len_q[3] : 8'h0, len_q.size() > 0 ? len_q[0] : 8'h0}),
            64'({8'd15, 8'd15}));
        chk("t1_beats", 64'(beat_cnt), 64'd64);
        chk("t1_pass_done", 64'(pd_cnt), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_adc_period", 64'(last_rise - prev_rise), 64'd6);
        check_data("t1_data", 256);

        // 2: partial last word
        run_size55("t2");

        // 3: ring capture with stop after 5us
        start_run(16'd1, 24'd256, 1'b1);
        repeat (1250) @(posedge aclk);
        #1 ctl_stop = 1'b1;
        @(posedge aclk); #1;
        ctl_stop = 1'b0;
        chk("t3_adc_halt", 64'(adc_clk), 64'd0);
        wait_done(500, "t3_done");
        chk("t3_pass_done", 64'(pd_cnt), 64'd2);
        chk("t3_cmds", 64'(cmd_cnt), 64'd10);
        chk("t3_wrap4", 64'(addr_at(4)), 64'(BASE));
        chk("t3_wrap8", 64'(addr_at(8)), 64'(BASE + 32'd0));
        chk("t3_beats", 64'(beat_cnt), 64'd160);
        chk("t3_pads", 64'(pad_cnt > 0), 64'd1);
        chk("t3_busy_end", 64'(busy), 64'd0);

        // 4: overrun with data path stalled
        wdata_ready = 1'b0;
        start_run(16'd1, 24'd256, 1'b0);
        for (int i = 0; i < 1000 && !overrun; i++) begin
            @(negedge aclk); #1;
        end
        chk("t4_overrun", 64'(overrun), 64'd1);
        chk("t4_samples", 64'(rise_cnt), 64'd68);
        repeat (10) @(posedge aclk);
        #1;
        chk("t4_drain_wait", 64'({busy, adc_clk}), 64'b10);
        wdata_ready = 1'b1;
        wait_done(200, "t4_done");
        chk("t4_beats", 64'(beat_cnt), 64'd16);
        chk("t4_pads", 64'(pad_cnt), 64'd0);
        check_data("t4_data", 64);
        chk("t4_sticky", 64'(overrun), 64'd1);

        // 5: rejected starts
        clr = 1'b1;
        @(posedge aclk); #1;
        clr = 1'b0;
        bad_start(16'd0, BASE, 24'd64, "t5_div");
        bad_start(16'd3, BASE, 24'd0, "t5_size");
        bad_start(16'd3, 32'h2000_0002, 24'd64, "t5_addr");
        chk("t5_err_cnt", 64'(err_cnt), 64'd3);
        chk("t5_no_cmd", 64'(cv_seen), 64'd0);
        chk("t5_overrun_kept", 64'(overrun), 64'd1);

        // 6: valid start clears overrun, then reset mid-burst
        start_run(16'd3, 24'd256, 1'b0);
        chk("t6_overrun_clr", 64'(overrun), 64'd0);
        repeat (300) @(posedge aclk);
        #1;
        chk("t6_mid_burst", 64'(beat_cnt > 0 && busy), 64'd1);
        areset = 1'b1;
        @(posedge aclk); #1;
        check_outputs_zero("t6_reset");
        areset = 1'b0;
        @(posedge aclk); #1;
        run_size55("t6_rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
